dsp_mac_pipe: RTL and testbench
===============================

Name: dsp_mac_pipe

Overview:
Parametrised signed multiply-accumulate pipeline that generalises the fixed single-register DSP48E1 multiply test. Input, multiplier and accumulator register depths, operand widths and accumulator width are all parameters. Data travels with a valid/clear sideband and can be stalled by a clock enable, so streams with bubbles accumulate correctly. The block is the RTL golden model and a DSP48E1 inference target for the DSP register-configuration minitests.

Parameters:
A_WIDTH, 18, signed A operand width (2..25)
B_WIDTH, 18, signed B operand width (2..18)
P_WIDTH, 48, accumulator/output width; must be >= A_WIDTH+B_WIDTH, checked at elaboration
IREG, 1, input register stages on A/B/control (0..2)
MREG, 1, product register stages (0..1)

Ports:
clk  input  1  clock; all registers on the rising edge
rst_n  input  1  asynchronous active-low reset
ce  input  1  global clock enable; 0 freezes every pipeline register, including valid bits
in_valid  input  1  a/b/acc_load are meaningful this cycle
acc_load  input  1  with in_valid: start a new sum (P = product) instead of P = P + product
a  input  A_WIDTH  signed multiplicand
b  input  B_WIDTH  signed multiplier
out_valid  output  1  p holds a fresh accumulator result
p  output  P_WIDTH  signed accumulator
sat_flag  output  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Reset, asynchronous on rst_n low: every data, valid and flag register clears at once. p=0, out_valid=0, sat_flag=0. Any in-flight samples are discarded. The first sample after reset release must carry acc_load=1; if it does not, it accumulates onto 0.
- Pipeline order: input regs (IREG) -> signed multiply (A_WIDTH+B_WIDTH bits) -> product regs (MREG) -> accumulator register P (always present).
- Latency L = IREG+MREG+1 cycles with ce held 1. A sample presented at edge n appears on p/out_valid after edge n+L.
- The valid bit and acc_load travel in lockstep with their data through every stage.
- ce=0: no register updates anywhere. Outputs hold their values, and out_valid holds too, so a stalled valid is not consumed twice downstream. Cycles with ce=0 add to latency one for one.
- Accumulator update on a ce=1 edge, where S is the sign-extended product at the last stage:
  - valid & load -> P=S
  - valid & !load -> P=P+S
  - !valid -> P holds
  - out_valid <= final-stage valid.
- Arithmetic: two's complement. The sum is computed in P_WIDTH+1 bits. Without saturation the result wraps modulo 2^P_WIDTH.
- acc_load together with an incoming bubble has no effect; load is only honoured when in_valid=1.
- IREG=0 and MREG=0 are legal: the multiplier path is combinational into P, and L=1.

Optional Feature:
Macro DSP_MAC_SAT_EN.
- Defined: if the P_WIDTH+1-bit sum leaves the signed P_WIDTH range, P clamps to +(2^(P_WIDTH-1)-1) or -2^(P_WIDTH-1). sat_flag is set sticky on that edge and clears only on a valid acc_load update that itself does not saturate, or on reset.
- Not defined: results wrap and sat_flag is tied to 0. No saturation logic is generated.

Test Plan:
- Defaults. Pulse in_valid with a=3, b=4, acc_load=1, then two samples a=3, b=4 with acc_load=0 -> out_valid on cycles 3,4,5 with p=12, 24, 36.
- Defaults. a=-131072, b=-131072, acc_load=1 -> p=17179869184 after 3 cycles. Next sample a=-1, b=5, acc_load=0 -> p=17179869179.
- Bubbles and stall. Samples (2,5,load), bubble, (1,-7), with ce=0 for 2 cycles mid-stream -> p=10, then 3. out_valid high for exactly 2 ce-enabled cycles; p is unchanged during the stall.
- Reset mid-operation. After accumulating p=36, drive rst_n=0 asynchronously between edges -> p=0 and out_valid=0 immediately. A new (6,7,load) yields 42.
- P_WIDTH=36, IREG=0, MREG=0. Two samples (-131072,-131072), load then accumulate:
  - without DSP_MAC_SAT_EN -> p=-34359738368, sat_flag=0
  - with DSP_MAC_SAT_EN -> p=34359738367, sat_flag=1; stays 1 until a (1,1,load) gives p=1, sat_flag=0.
- IREG=2, MREG=1 -> latency 4. Back-to-back valid samples produce back-to-back out_valid with no gaps.

Source files
------------

// File: rtl/dsp_mac_pipe.sv
// Parametrised signed multiply-accumulate pipeline: IREG input stages, MREG product stages, then accumulator P.
// Optional saturation of P with a sticky sat_flag is enabled by defining DSP_MAC_SAT_EN.
module dsp_mac_pipe #(
  parameter int A_WIDTH = 18,
  parameter int B_WIDTH = 18,
  parameter int P_WIDTH = 48,
  parameter int IREG    = 1,
  parameter int MREG    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic                      in_valid,
  input  logic                      acc_load,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  output logic                      out_valid,
  output logic signed [P_WIDTH-1:0] p,
  output logic                      sat_flag
);

  localparam int M_WIDTH = A_WIDTH + B_WIDTH;
  localparam int I_WORD  = M_WIDTH + 2;
  localparam int M_WORD  = M_WIDTH + 2;

  generate
    if (P_WIDTH < M_WIDTH) begin : g_chk_pw
      $error("dsp_mac_pipe: P_WIDTH must be >= A_WIDTH+B_WIDTH");
    end
    if (IREG < 0 || IREG > 2) begin : g_chk_ireg
      $error("dsp_mac_pipe: IREG must be 0..2");
    end
    if (MREG < 0 || MREG > 1) begin : g_chk_mreg
      $error("dsp_mac_pipe: MREG must be 0..1");
    end
  endgenerate

  // Input stages carry {valid, load, a, b} as one word so sideband stays aligned with data.
  logic [I_WORD-1:0] in_word;
  logic [I_WORD-1:0] ireg_word;

  assign in_word = {in_valid, acc_load, a, b};

  generate
    if (IREG > 0) begin : g_ireg
      logic [I_WORD-1:0] stage [IREG];

      // NOTE: non-blocking assignments, so every stage samples its predecessor's pre-edge value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          // NOTE: data words are cleared with the valid bits so no stale operand survives a reset.
          for (int i = 0; i < IREG; i++) stage[i] <= '0;
        end else if (ce) begin
          stage[0] <= in_word;
          for (int i = 1; i < IREG; i++) stage[i] <= stage[i-1];
        end
      end

      assign ireg_word = stage[IREG-1];
    end else begin : g_no_ireg
      assign ireg_word = in_word;
    end
  endgenerate

  logic                      valid_i;
  logic                      load_i;
  logic signed [A_WIDTH-1:0] a_i;
  logic signed [B_WIDTH-1:0] b_i;
  logic signed [M_WIDTH-1:0] a_ext;
  logic signed [M_WIDTH-1:0] b_ext;
  logic signed [M_WIDTH-1:0] prod_c;

  assign {valid_i, load_i, a_i, b_i} = ireg_word;

  // Operands are widened to the full product width so the multiply is exact and width-clean.
  assign a_ext  = {{B_WIDTH{a_i[A_WIDTH-1]}}, a_i};
  assign b_ext  = {{A_WIDTH{b_i[B_WIDTH-1]}}, b_i};
  assign prod_c = a_ext * b_ext;

  logic [M_WORD-1:0] mreg_in;
  logic [M_WORD-1:0] mreg_word;

  assign mreg_in = {valid_i, load_i, prod_c};

  generate
    if (MREG > 0) begin : g_mreg
      logic [M_WORD-1:0] stage;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  stage <= '0;
        else if (ce) stage <= mreg_in;
      end

      assign mreg_word = stage;
    end else begin : g_no_mreg
      assign mreg_word = mreg_in;
    end
  endgenerate

  logic                      valid_m;
  logic                      load_m;
  logic signed [M_WIDTH-1:0] prod_m;
  logic signed [P_WIDTH-1:0] s_ext;
  logic signed [P_WIDTH-1:0] base;
  logic signed [P_WIDTH-1:0] p_next;

  assign {valid_m, load_m, prod_m} = mreg_word;
  assign s_ext = P_WIDTH'(prod_m);
  assign base  = load_m ? '0 : p;

`ifdef DSP_MAC_SAT_EN
  localparam int SUM_W = P_WIDTH + 1;

  logic signed [SUM_W-1:0] sum;
  logic                    ovf;

  assign sum = SUM_W'(base) + SUM_W'(s_ext);
  assign ovf = sum[P_WIDTH] ^ sum[P_WIDTH-1];

  // NOTE: p_next takes its default first, so every path assigns it and no latch is inferred.
  always_comb begin
    p_next = sum[P_WIDTH-1:0];
    if (ovf) begin
      p_next = sum[P_WIDTH] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}};
    end
  end

  // Sticky until a valid load that lands in range starts a clean sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (ce && valid_m) begin
      if (ovf)         sat_flag <= 1'b1;
      else if (load_m) sat_flag <= 1'b0;
    end
  end
`else
  assign p_next   = base + s_ext;
  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p         <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= valid_m;
      if (valid_m) p <= p_next;
    end
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Self-checking bench for dsp_mac_pipe: three configurations share stimulus and are compared
// against directed expectations and a latency/accumulate reference model.
module tb_dsp_mac_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic acc_load = 1'b0;
  logic signed [17:0] a = '0;
  logic signed [17:0] b = '0;

  logic ov0, ov1, ov2;
  logic sf0, sf1, sf2;
  logic signed [47:0] p0;
  logic signed [35:0] p1;
  logic signed [47:0] p2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe u_def (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .acc_load(acc_load),
    .a(a), .b(b), .out_valid(ov0), .p(p0), .sat_flag(sf0)
  );

  dsp_mac_pipe #(.P_WIDTH(36), .IREG(0), .MREG(0)) u_p36 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .acc_load(acc_load),
    .a(a), .b(b), .out_valid(ov1), .p(p1), .sat_flag(sf1)
  );

  dsp_mac_pipe #(.IREG(2), .MREG(1)) u_deep (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .acc_load(acc_load),
    .a(a), .b(b), .out_valid(ov2), .p(p2), .sat_flag(sf2)
  );

  longint dp [3];
  logic   dov[3];
  logic   dsf[3];

  assign dp[0] = {{16{p0[47]}}, p0};
  assign dp[1] = {{28{p1[35]}}, p1};
  assign dp[2] = {{16{p2[47]}}, p2};
  assign dov[0] = ov0;
  assign dov[1] = ov1;
  assign dov[2] = ov2;
  assign dsf[0] = sf0;
  assign dsf[1] = sf1;
  assign dsf[2] = sf2;

  // Reference model: each configuration is a delay line of L-1 samples in front of an
  // arithmetic accumulator working on plain 64-bit integers.
  typedef struct packed {
    logic   v;
    logic   ld;
    longint prod;
  } samp_t;

  int     lat[3] = '{3, 1, 4};
  int     pw [3] = '{48, 36, 48};
  samp_t  dl [3][3];
  longint m_p [3];
  logic   m_ov[3];
  logic   m_sf[3];

  function automatic longint wrapw(input longint x, input int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    samp_t  in_s;
    samp_t  out_s;
    longint full;
    longint hi;
    longint lo;
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_p[d] = 0;
        m_ov[d] = 1'b0;
        m_sf[d] = 1'b0;
        for (int k = 0; k < 3; k++) dl[d][k] = '0;
      end
    end else if (ce) begin
      for (int d = 0; d < 3; d++) begin
        in_s.v = in_valid;
        in_s.ld = acc_load;
        in_s.prod = longint'(a) * longint'(b);
        if (lat[d] == 1) begin
          out_s = in_s;
        end else begin
          out_s = dl[d][lat[d]-2];
          for (int k = lat[d] - 2; k > 0; k--) dl[d][k] = dl[d][k-1];
          dl[d][0] = in_s;
        end
        m_ov[d] = out_s.v;
        if (out_s.v) begin
          full = (out_s.ld ? 64'sd0 : m_p[d]) + out_s.prod;
          hi = (64'sd1 <<< (pw[d] - 1)) - 1;
          lo = -hi - 1;
`ifdef DSP_MAC_SAT_EN
          if (full > hi) begin
            m_p[d] = hi;
            m_sf[d] = 1'b1;
          end else if (full < lo) begin
            m_p[d] = lo;
            m_sf[d] = 1'b1;
          end else begin
            m_p[d] = full;
            if (out_s.ld) m_sf[d] = 1'b0;
          end
`else
          m_p[d] = wrapw(full, pw[d]);
          if (hi < lo) m_sf[d] = 1'b1;
`endif
        end
      end
    end
  end

  task automatic drive_cycle(input logic v, input logic ld, input int av, input int bv, input logic c);
    @(negedge clk);
    in_valid = v;
    acc_load = ld;
    a = 18'(av);
    b = 18'(bv);
    ce = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    acc_load = 1'b0;
    a = '0;
    b = '0;
    ce = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ce = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (dp[d] !== 0) begin
        errors++;
        $display("FAIL reset_p dut%0d: got %0d want 0", d, dp[d]);
      end
      checks++;
      if (dov[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid dut%0d: got %b want 0", d, dov[d]);
      end
      checks++;
      if (dsf[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_sat_flag dut%0d: got %b want 0", d, dsf[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic   v  [6] = '{1, 1, 1, 0, 0, 0};
    logic   ld [6] = '{1, 0, 0, 0, 0, 0};
    logic   eov[6] = '{0, 0, 1, 1, 1, 0};
    longint ep [6] = '{0, 0, 12, 24, 36, 36};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(v[i], ld[i], 3, 4, 1'b1);
      checks++;
      if (dov[0] !== eov[i]) begin
        errors++;
        $display("FAIL basic_out_valid edge%0d: got %b want %b", i + 1, dov[0], eov[i]);
      end
      checks++;
      if (dp[0] !== ep[i]) begin
        errors++;
        $display("FAIL basic_p edge%0d: got %0d want %0d", i + 1, dp[0], ep[i]);
      end
    end
  endtask

  task automatic test_big();
    longint ep[5] = '{0, 0, 64'sd17179869184, 64'sd17179869179, 64'sd17179869179};
    logic   eov[5] = '{0, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive_cycle(1'b1, 1'b1, -131072, -131072, 1'b1);
      else if (i == 1) drive_cycle(1'b1, 1'b0, -1, 5, 1'b1);
      else             drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
      checks++;
      if (dp[0] !== ep[i] || dov[0] !== eov[i]) begin
        errors++;
        $display("FAIL big_operands edge%0d: got p=%0d ov=%b want p=%0d ov=%b",
                 i + 1, dp[0], dov[0], ep[i], eov[i]);
      end
    end
  endtask

  task automatic test_bubble_stall();
    logic   v  [9] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
    logic   ld [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    int     av [9] = '{2, 0, 1, 0, 0, 0, 0, 0, 0};
    int     bv [9] = '{5, 0, -7, 0, 0, 0, 0, 0, 0};
    logic   c  [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
    logic   eov[9] = '{0, 0, 1, 1, 1, 0, 1, 0, 0};
    longint ep [9] = '{0, 0, 10, 10, 10, 10, 3, 3, 3};
    int     live_valid = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_cycle(v[i], ld[i], av[i], bv[i], c[i]);
      if (c[i] && dov[0]) live_valid++;
      checks++;
      if (dov[0] !== eov[i]) begin
        errors++;
        $display("FAIL stall_out_valid edge%0d: got %b want %b", i + 1, dov[0], eov[i]);
      end
      checks++;
      if (dp[0] !== ep[i]) begin
        errors++;
        $display("FAIL stall_p edge%0d: got %0d want %0d", i + 1, dp[0], ep[i]);
      end
    end
    checks++;
    if (live_valid !== 2) begin
      errors++;
      $display("FAIL stall_valid_count: got %0d want 2", live_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic   eov[4] = '{0, 0, 1, 0};
    longint ep [4] = '{0, 0, 42, 42};
    do_reset();
    drive_cycle(1'b1, 1'b1, 3, 4, 1'b1);
    drive_cycle(1'b1, 1'b0, 3, 4, 1'b1);
    drive_cycle(1'b1, 1'b0, 3, 4, 1'b1);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
    drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
    checks++;
    if (dp[0] !== 36) begin
      errors++;
      $display("FAIL midreset_pre_p: got %0d want 36", dp[0]);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dp[0] !== 0 || dov[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async_clear: got p=%0d ov=%b want p=0 ov=0", dp[0], dov[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_cycle(1'b1, 1'b1, 6, 7, 1'b1);
      else        drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
      checks++;
      if (dp[0] !== ep[i] || dov[0] !== eov[i]) begin
        errors++;
        $display("FAIL midreset_restart edge%0d: got p=%0d ov=%b want p=%0d ov=%b",
                 i + 1, dp[0], dov[0], ep[i], eov[i]);
      end
    end
  endtask

  task automatic test_sat();
`ifdef DSP_MAC_SAT_EN
    longint ep [5] = '{64'sd17179869184, 64'sd34359738367, 64'sd34359738367, 64'sd34359738367, 1};
    logic   esf[5] = '{0, 1, 1, 1, 0};
`else
    longint ep [5] = '{64'sd17179869184, -64'sd34359738368, -64'sd34359738368, -64'sd34359738368, 1};
    logic   esf[5] = '{0, 0, 0, 0, 0};
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive_cycle(1'b1, 1'b1, -131072, -131072, 1'b1);
        1:       drive_cycle(1'b1, 1'b0, -131072, -131072, 1'b1);
        2:       drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
        3:       drive_cycle(1'b1, 1'b0, 0, 0, 1'b1);
        default: drive_cycle(1'b1, 1'b1, 1, 1, 1'b1);
      endcase
      checks++;
      if (dp[1] !== ep[i]) begin
        errors++;
        $display("FAIL p36_p edge%0d: got %0d want %0d", i + 1, dp[1], ep[i]);
      end
      checks++;
      if (dsf[1] !== esf[i]) begin
        errors++;
        $display("FAIL p36_sat_flag edge%0d: got %b want %b", i + 1, dsf[1], esf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int     av[6];
    int     bv[6];
    longint run[6];
    longint acc = 0;
    logic   eov;
    longint ep;
    for (int i = 0; i < 6; i++) begin
      av[i] = int'($urandom_range(0, 262143)) - 131072;
      bv[i] = int'($urandom_range(0, 262143)) - 131072;
      acc = (i == 0 ? 64'sd0 : acc) + longint'(av[i]) * longint'(bv[i]);
      run[i] = acc;
    end
    do_reset();
    for (int e = 1; e <= 11; e++) begin
      if (e <= 6) drive_cycle(1'b1, e == 1, av[e-1], bv[e-1], 1'b1);
      else        drive_cycle(1'b0, 1'b0, 0, 0, 1'b1);
      eov = (e >= 4 && e <= 9);
      ep = (e < 4) ? 64'sd0 : run[(e - 4 > 5) ? 5 : e - 4];
      checks++;
      if (dov[2] !== eov) begin
        errors++;
        $display("FAIL deep_out_valid edge%0d: got %b want %b", e, dov[2], eov);
      end
      checks++;
      if (dp[2] !== ep) begin
        errors++;
        $display("FAIL deep_p edge%0d: got %0d want %0d", e, dp[2], ep);
      end
    end
  endtask

  task automatic test_random();
    int av;
    int bv;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      av = ($urandom_range(0, 3) == 0) ? -131072 : int'($urandom_range(0, 262143)) - 131072;
      bv = ($urandom_range(0, 3) == 0) ? -131072 : int'($urandom_range(0, 262143)) - 131072;
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, av, bv,
                  $urandom_range(0, 7) != 0);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dp[d] !== m_p[d]) begin
          errors++;
          $display("FAIL rand_p dut%0d cyc%0d: got %0d want %0d", d, i, dp[d], m_p[d]);
        end
        checks++;
        if (dov[d] !== m_ov[d]) begin
          errors++;
          $display("FAIL rand_out_valid dut%0d cyc%0d: got %b want %b", d, i, dov[d], m_ov[d]);
        end
        checks++;
        if (dsf[d] !== m_sf[d]) begin
          errors++;
          $display("FAIL rand_sat_flag dut%0d cyc%0d: got %b want %b", d, i, dsf[d], m_sf[d]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_big();
    test_bubble_stall();
    test_reset_mid();
    test_sat();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
